mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single external SPI memory controller between the CPU instruction-fetch
//  port (IF) and the load/store data port (DM). Latches one request at a time,
//  sequences the controller's level start/done handshake, and returns read data and a
//  one-cycle done pulse to the winner. Sits between the CPU core and mem_external.
// PARAMETERS
//  ADDR_W  32  byte address width on all ports
//  DATA_W  32  data width; read data left-aligned exactly as returned by the controller
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset; one clock; reset is synchronous and active-low
//  if_req       in   1       fetch request; held high until if_done
//  if_addr      in   ADDR_W  fetch address; always a 4-byte read
//  if_done      out  1       one-cycle pulse: if_rdata valid this cycle
//  if_rdata     out  DATA_W  fetched word
//  dm_req       in   1       data request; held high until dm_done
//  dm_we        in   1       1=store, 0=load
//  dm_nbytes    in   3       1, 2 or 4; any other value is illegal
//  dm_addr      in   ADDR_W  data address
//  dm_wdata     in   DATA_W  store data
//  dm_done      out  1       one-cycle pulse: dm_rdata valid / store finished
//  dm_rdata     out  DATA_W  load data
//  dm_err       out  1       one-cycle pulse with dm_done when dm_nbytes was illegal
//  mem_start    out  1       start_request to controller, level
//  mem_we       out  1       is_write
//  mem_nbytes   out  3       num_bytes
//  mem_addr     out  ADDR_W  target_address
//  mem_wdata    out  DATA_W  write_value
//  mem_rdata    in   DATA_W  fetched_data
//  mem_done     in   1       request_done, level
//  busy         out  1       high in any state other than IDLE
//  grant_dm     out  1       owner of current/last transaction: 1=DM, 0=IF
// BEHAVIOUR
//  - Reset: state=IDLE; every output 0; all latched request fields 0.
//  - Reset mid-transaction: abandon immediately; no done is issued.
//  - States:
//    IDLE: sample requests. If either request is high, latch the winner's addr, we,
//      nbytes and wdata into mem_* registers. For IF, we=0 and nbytes=4. Set mem_start=1
//      and go to BUSY.
//      Illegal dm_nbytes: no memory access; pulse dm_done+dm_err next cycle with
//      dm_rdata=0, then go to RELEASE.
//    BUSY: hold all mem_* stable. On mem_done=1, register mem_rdata into the winner's
//      rdata, pulse the winner's done for exactly 1 cycle, clear mem_start, go RELEASE.
//    RELEASE: wait for mem_done=0, then go to IDLE. Minimum dwell is 1 cycle, even if
//      mem_done is already low.
//  - Requester rule: the requester drops req in the cycle after it sees done. Requests
//    are sampled only in IDLE, so no stale re-grant can occur.
//  - Latency: req high in IDLE -> mem_start at the next edge. done follows the edge
//    after mem_done rises. Back-to-back grants are separated by >=2 cycles.
//  - Priority (default build): DM beats IF when both are high in the same IDLE cycle.
//  - rdata registers hold their value until the next done for that port.
//  - mem_done high while in IDLE is ignored.
// CONFIGURATION
//  MEM_ARB_RR_EN
//    defined:   round-robin. On a tie, the port not granted last wins. grant_dm
//               records the last winner; after reset, DM is treated as last, so IF wins
//               the first tie.
//    undefined: fixed DM-over-IF priority as above.
// STRUCTURE
//  - Package mem_arb_pkg:
//    state enum ARB_IDLE/ARB_BUSY/ARB_RELEASE;
//    requester ids ARB_ID_IF=0, ARB_ID_DM=1;
//    nbytes constants NB_1=3'd1, NB_2=3'd2, NB_4=3'd4;
//    function nbytes_legal().
//  - Sub-module mem_arb_select: combinational winner pick (fixed or RR) from
//    if_req, dm_req and last grant.
//  - The FSM, registers and handshake live in mem_arbiter.
// TESTING
//  1. IF only: if_addr=0x000010, controller model asserts mem_done 40 cycles later with
//     0x00A00093 -> mem_we=0, mem_nbytes=4, if_done pulses 1 cycle, if_rdata=0x00A00093.
//  2. Store: dm_we=1, dm_nbytes=2, dm_addr=0x1004, dm_wdata=0xBEEF -> mem_we=1,
//     mem_nbytes=2, mem_wdata=0xBEEF held stable through BUSY, dm_done=1, dm_err=0.
//  3. Tie with if_req=dm_req=1 in IDLE -> DM served first, IF served next. Under
//     MEM_ARB_RR_EN the first tie goes to IF and the second tie to DM.
//  4. dm_nbytes=3 -> mem_start never rises; dm_done=dm_err=1 for 1 cycle; dm_rdata=0.
//  5. Controller holds mem_done high for 5 cycles after completion -> arbiter stays in
//     RELEASE; a pending if_req is granted only after mem_done falls.
//  6. rst_n=0 for 1 cycle in mid-BUSY -> next cycle all outputs 0; no done pulse.
//     A new request after reset completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the CPU-side SPI memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_t;

  localparam logic ARB_ID_IF = 1'b0;
  localparam logic ARB_ID_DM = 1'b1;

  localparam logic [2:0] NB_1 = 3'd1;
  localparam logic [2:0] NB_2 = 3'd2;
  localparam logic [2:0] NB_4 = 3'd4;

  function automatic logic nbytes_legal(input logic [2:0] nb);
    return (nb == NB_1) || (nb == NB_2) || (nb == NB_4);
  endfunction

endpackage

// File: rtl/mem_arb_if.sv
// Request ports (IF, DM), controller handshake and status of mem_arbiter.
// slave = arbiter view, master = CPU/controller environment view.
interface mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_rdata;

  logic              dm_req;
  logic              dm_we;
  logic [2:0]        dm_nbytes;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_err;

  logic              mem_start;
  logic              mem_we;
  logic [2:0]        mem_nbytes;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  logic              busy;
  logic              grant_dm;

  modport slave (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_nbytes, dm_addr, dm_wdata,
    input  mem_rdata, mem_done,
    output if_done, if_rdata,
    output dm_done, dm_rdata, dm_err,
    output mem_start, mem_we, mem_nbytes, mem_addr, mem_wdata,
    output busy, grant_dm
  );

  modport master (
    output if_req, if_addr,
    output dm_req, dm_we, dm_nbytes, dm_addr, dm_wdata,
    output mem_rdata, mem_done,
    input  if_done, if_rdata,
    input  dm_done, dm_rdata, dm_err,
    input  mem_start, mem_we, mem_nbytes, mem_addr, mem_wdata,
    input  busy, grant_dm
  );
endinterface

// File: rtl/mem_arb_select.sv
// Combinational winner pick between IF and DM.
// MEM_ARB_RR_EN selects round-robin on ties; default is fixed DM-over-IF.
module mem_arb_select (
  input  logic if_req,
  input  logic dm_req,
  input  logic last_dm,
  output logic any_req,
  output logic pick_dm
);

  assign any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
  // On a tie the port that did not win last time takes the grant.
  assign pick_dm = dm_req & (~if_req | ~last_dm);
`else
  logic unused_last_dm;
  assign unused_last_dm = last_dm;
  assign pick_dm        = dm_req;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the SPI memory controller between instruction fetch and data ports.
// Tie policy set by MEM_ARB_RR_EN (see mem_arb_select).
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  mem_arb_if.slave bus
);

  arb_state_t state;
  logic       last_dm;
  logic       any_req;
  logic       pick_dm;

  mem_arb_select u_sel (
    .if_req  (bus.if_req),
    .dm_req  (bus.dm_req),
    .last_dm (last_dm),
    .any_req (any_req),
    .pick_dm (pick_dm)
  );

  assign bus.busy = (state != ARB_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ARB_IDLE;
      // DM counts as the previous winner so a round-robin first tie goes to IF.
      last_dm        <= ARB_ID_DM;
      bus.grant_dm   <= 1'b0;
      bus.if_done    <= 1'b0;
      bus.if_rdata   <= '0;
      bus.dm_done    <= 1'b0;
      bus.dm_rdata   <= '0;
      bus.dm_err     <= 1'b0;
      bus.mem_start  <= 1'b0;
      bus.mem_we     <= 1'b0;
      bus.mem_nbytes <= '0;
      bus.mem_addr   <= '0;
      bus.mem_wdata  <= '0;
    end else begin
      bus.if_done <= 1'b0;
      bus.dm_done <= 1'b0;
      bus.dm_err  <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            bus.grant_dm <= pick_dm;
            last_dm      <= pick_dm;
            if (pick_dm && !nbytes_legal(bus.dm_nbytes)) begin
              // Illegal size never reaches the controller.
              bus.dm_done  <= 1'b1;
              bus.dm_err   <= 1'b1;
              bus.dm_rdata <= '0;
              state        <= ARB_RELEASE;
            end else begin
              bus.mem_start  <= 1'b1;
              bus.mem_we     <= pick_dm & bus.dm_we;
              bus.mem_nbytes <= pick_dm ? bus.dm_nbytes : NB_4;
              bus.mem_addr   <= pick_dm ? bus.dm_addr : bus.if_addr;
              bus.mem_wdata  <= pick_dm ? bus.dm_wdata : '0;
              state          <= ARB_BUSY;
            end
          end
        end
        ARB_BUSY: begin
          if (bus.mem_done) begin
            bus.mem_start <= 1'b0;
            if (bus.grant_dm) begin
              bus.dm_rdata <= bus.mem_rdata;
              bus.dm_done  <= 1'b1;
            end else begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_done  <= 1'b1;
            end
            state <= ARB_RELEASE;
          end
        end
        ARB_RELEASE: begin
          if (!bus.mem_done) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a delay/hold-programmable controller model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [2:0]  nb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        chk_rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ctl_delay = 3, ctl_hold = 1, ctl_cnt = 0, hold_cnt = 0, start_cnt = 0;
  logic last_model = 1'b1;
  logic prev_start = 1'b0, prev_mdone = 1'b0, prev_ifd = 1'b0, prev_dmd = 1'b0;
  logic        cap_we;
  logic [2:0]  cap_nb;
  logic [31:0] cap_addr, cap_wdata;

  function automatic logic [31:0] ctl_data(input logic [31:0] a);
    return a ^ 32'h00A0_0083;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: controller model acts 1ns after the edge, monitor 1ns later.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      bus.mem_done = 1'b0;
      ctl_cnt      = 0;
    end else if (bus.mem_done) begin
      if (hold_cnt > 1) hold_cnt--;
      else bus.mem_done = 1'b0;
    end else if (bus.mem_start) begin
      ctl_cnt++;
      if (ctl_cnt >= ctl_delay) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = ctl_data(bus.mem_addr);
        hold_cnt      = ctl_hold;
        ctl_cnt       = 0;
      end
    end else begin
      ctl_cnt = 0;
    end
    #1;
    if (bus.mem_start && !prev_start) begin
      start_cnt++;
      cap_we = bus.mem_we; cap_nb = bus.mem_nbytes;
      cap_addr = bus.mem_addr; cap_wdata = bus.mem_wdata;
      if (sb.size() == 0) chk("unexp_start", 32'd1, 32'd0);
      else begin
        chk("st_we",    {31'd0, bus.mem_we}, {31'd0, sb[0].we});
        chk("st_nb",    {29'd0, bus.mem_nbytes}, {29'd0, sb[0].nb});
        chk("st_addr",  bus.mem_addr, sb[0].addr);
        chk("st_wdata", bus.mem_wdata, sb[0].wdata);
      end
    end else if (bus.mem_start) begin
      chk("busy_stable", {31'd0, (bus.mem_we !== cap_we) || (bus.mem_nbytes !== cap_nb) ||
          (bus.mem_addr !== cap_addr) || (bus.mem_wdata !== cap_wdata)}, 32'd0);
    end
    if (bus.if_done || bus.dm_done) begin
      chk("one_done", {31'd0, bus.if_done & bus.dm_done}, 32'd0);
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("done_port", {31'd0, bus.dm_done}, {31'd0, e.is_dm});
        chk("grant",     {31'd0, bus.grant_dm}, {31'd0, e.is_dm});
        chk("err",       {31'd0, bus.dm_err}, {31'd0, e.err});
        if (e.chk_rd) chk("rdata", e.is_dm ? bus.dm_rdata : bus.if_rdata, e.rdata);
        if (!e.err) chk("done_lat", {31'd0, prev_mdone}, 32'd1);
      end
      if (bus.if_done) bus.if_req = 1'b0;
      if (bus.dm_done) bus.dm_req = 1'b0;
    end
    if (prev_ifd) chk("if_pulse", {31'd0, bus.if_done}, 32'd0);
    if (prev_dmd) chk("dm_pulse", {31'd0, bus.dm_done}, 32'd0);
    prev_start = bus.mem_start;
    prev_mdone = bus.mem_done;
    prev_ifd   = bus.if_done;
    prev_dmd   = bus.dm_done;
  endtask

  function automatic exp_t mk_if(input logic [31:0] a);
    exp_t e;
    e.is_dm = 1'b0; e.we = 1'b0; e.nb = NB_4; e.addr = a; e.wdata = '0;
    e.rdata = ctl_data(a); e.chk_rd = 1'b1; e.err = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk_dm(input logic we, input logic [2:0] nb,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    e.is_dm = 1'b1; e.we = we; e.nb = nb; e.addr = a; e.wdata = wd;
    e.err   = !((nb == NB_1) || (nb == NB_2) || (nb == NB_4));
    e.rdata = e.err ? 32'd0 : ctl_data(a);
    e.chk_rd = e.err || !we;
    return e;
  endfunction

  task automatic drive_if(input logic [31:0] a);
    bus.if_addr = a; bus.if_req = 1'b1;
  endtask

  task automatic drive_dm(input logic we, input logic [2:0] nb,
                          input logic [31:0] a, input logic [31:0] wd);
    bus.dm_we = we; bus.dm_nbytes = nb; bus.dm_addr = a; bus.dm_wdata = wd; bus.dm_req = 1'b1;
  endtask

  task automatic issue_if(input logic [31:0] a);
    sb.push_back(mk_if(a)); last_model = ARB_ID_IF; drive_if(a);
  endtask

  task automatic issue_dm(input logic we, input logic [2:0] nb,
                          input logic [31:0] a, input logic [31:0] wd);
    sb.push_back(mk_dm(we, nb, a, wd)); last_model = ARB_ID_DM; drive_dm(we, nb, a, wd);
  endtask

  task automatic issue_tie(input logic [31:0] ia, input logic [31:0] da);
    logic if_first;
`ifdef MEM_ARB_RR_EN
    if_first = last_model;
`else
    if_first = 1'b0;
`endif
    if (if_first) begin
      sb.push_back(mk_if(ia)); sb.push_back(mk_dm(1'b0, NB_4, da, '0)); last_model = ARB_ID_DM;
    end else begin
      sb.push_back(mk_dm(1'b0, NB_4, da, '0)); sb.push_back(mk_if(ia)); last_model = ARB_ID_IF;
    end
    drive_if(ia);
    drive_dm(1'b0, NB_4, da, '0);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((bus.if_req || bus.dm_req || bus.busy || sb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk("quiet_timeout", {31'd0, n < budget}, 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, {31'd0, bus.mem_start}, 32'd0);
    chk({tag, "_busy"},  {31'd0, bus.busy}, 32'd0);
    chk({tag, "_grant"}, {31'd0, bus.grant_dm}, 32'd0);
    chk({tag, "_dones"}, {29'd0, bus.if_done, bus.dm_done, bus.dm_err}, 32'd0);
    chk({tag, "_ifrd"},  bus.if_rdata, 32'd0);
    chk({tag, "_dmrd"},  bus.dm_rdata, 32'd0);
    chk({tag, "_memctl"}, {28'd0, bus.mem_we, bus.mem_nbytes}, 32'd0);
    chk({tag, "_maddr"}, bus.mem_addr, 32'd0);
    chk({tag, "_mwdat"}, bus.mem_wdata, 32'd0);
  endtask

  initial begin
    int n;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_nbytes = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_rdata = '0; bus.mem_done = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick();

    // IF-only fetch with a slow controller
    ctl_delay = 40;
    issue_if(32'h0000_0010);
    tick();
    chk("if_start_lat", {31'd0, bus.mem_start}, 32'd1);
    wait_quiet(200);
    chk("if_rdata_val", bus.if_rdata, 32'h00A0_0093);

    // Store, mem_* stability checked every BUSY cycle by the monitor
    ctl_delay = 6;
    issue_dm(1'b1, NB_2, 32'h0000_1004, 32'h0000_BEEF);
    tick();
    chk("st_mem_we", {31'd0, bus.mem_we}, 32'd1);
    wait_quiet(100);
    chk("if_rdata_hold", bus.if_rdata, 32'h00A0_0093);

    // Two consecutive ties
    ctl_delay = 3;
    issue_tie(32'h0000_0020, 32'h0000_2000);
    wait_quiet(100);
    issue_tie(32'h0000_0024, 32'h0000_2008);
    wait_quiet(100);

    // Illegal size: no controller access, error pulse, rdata cleared
    n = start_cnt;
    issue_dm(1'b0, 3'd3, 32'h0000_3000, '0);
    wait_quiet(50);
    chk("illegal_no_start", n, start_cnt);
    chk("illegal_rdata", bus.dm_rdata, 32'd0);

    // Sticky mem_done: pending IF must wait in RELEASE
    ctl_hold = 5;
    issue_dm(1'b0, NB_4, 32'h0000_4000, '0);
    n = 0;
    while (bus.dm_req && n < 100) begin tick(); n++; end
    chk("dm_done_timeout", {31'd0, n < 100}, 32'd1);
    issue_if(32'h0000_0040);
    n = 0;
    while (bus.mem_done && n < 20) begin
      chk("rel_no_start", {31'd0, bus.mem_start}, 32'd0);
      chk("rel_busy", {31'd0, bus.busy}, 32'd1);
      tick();
      n++;
    end
    chk("rel_hold_len", {31'd0, n >= 3 && n < 20}, 32'd1);
    ctl_hold = 1;
    wait_quiet(100);

    // Reset in mid-BUSY abandons the fetch silently
    ctl_delay = 40;
    issue_if(32'h0000_0080);
    repeat (10) tick();
    chk("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    bus.if_req = 1'b0;
    sb.delete();
    last_model = 1'b1;
    tick();
    rst_n = 1'b1;
    chk_all_zero("mid_rst");
    repeat (50) tick();
    ctl_delay = 3;
    issue_if(32'h0000_0084);
    wait_quiet(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
